// File: rtl/stack_arbiter.sv
// Round-robin arbiter that lets NREQ clients share one stack.
// A grant takes three cycles: IDLE (arbitrate) -> ISSUE (strobe) -> RESP (reply).
module stack_arbiter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NREQ  = 4,
    parameter int unsigned ID_W  = 2
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic [NREQ-1:0]       i_ReqVld,
    input  logic [NREQ-1:0]       i_ReqOp,
    input  logic [NREQ*WIDTH-1:0] i_ReqDat,
    output logic [NREQ-1:0]       o_ReqRdy,
    output logic [NREQ-1:0]       o_RspVld,
    output logic [WIDTH-1:0]      o_RspDat,
    output logic                  o_RspErr,
    output logic                  o_Busy,
    output logic                  o_StPush,
    output logic                  o_StPop,
    output logic [WIDTH-1:0]      o_StPushDat,
    input  logic [WIDTH-1:0]      i_StPopDat,
    input  logic                  i_StEmpty,
    input  logic                  i_StFull
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_q;
    logic [ID_W-1:0]   grant_q;
    logic [ID_W-1:0]   grant_c;
    logic              found_c;
    logic              op_q;
    logic [WIDTH-1:0]  dat_q;
    logic [WIDTH-1:0]  rsp_dat_q;
    logic              err_q;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        grant_c = '0;
        found_c = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found_c && i_ReqVld[ID_W'((32'(rr_q) + i) % NREQ)]) begin
                found_c = 1'b1;
                grant_c = ID_W'((32'(rr_q) + i) % NREQ);
            end
        end
    end

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        o_ReqRdy    = '0;
        o_RspVld    = '0;
        o_RspDat    = '0;
        o_RspErr    = 1'b0;
        o_StPush    = 1'b0;
        o_StPop     = 1'b0;
        o_StPushDat = '0;
        case (state_q)
            IDLE: begin
                if (found_c) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                o_ReqRdy[grant_q] = 1'b1;
                if (op_q && !i_StFull) begin
                    o_StPush    = 1'b1;
                    o_StPushDat = dat_q;
                end else if (!op_q && !i_StEmpty) begin
                    o_StPop = 1'b1;
                end
                state_d = RESP;
            end
            RESP: begin
                o_RspVld[grant_q] = 1'b1;
                o_RspDat          = rsp_dat_q;
                o_RspErr          = err_q;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_Busy = (state_q != IDLE);

    // Grant latch, legality result and pointer advance.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            rr_q      <= '0;
            grant_q   <= '0;
            op_q      <= 1'b0;
            dat_q     <= '0;
            rsp_dat_q <= '0;
            err_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && found_c) begin
                grant_q <= grant_c;
                op_q    <= i_ReqOp[grant_c];
                dat_q   <= i_ReqDat[32'(grant_c)*WIDTH +: WIDTH];
            end
            if (state_q == ISSUE) begin
                rr_q      <= (grant_q == ID_W'(NREQ - 1)) ? '0 : grant_q + ID_W'(1);
                err_q     <= op_q ? i_StFull : i_StEmpty;
                rsp_dat_q <= (!op_q && !i_StEmpty) ? i_StPopDat : '0;
            end
        end
    end

endmodule

// File: tb/tb_stack_arbiter.sv
// Directed bench for stack_arbiter with a small behavioural stack on the far side.
module tb_stack_arbiter;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned ID_W  = 2;
    localparam int unsigned DEPTH = 8;

    logic                  i_Clk = 1'b0;
    logic                  i_Rst;
    logic [NREQ-1:0]       i_ReqVld;
    logic [NREQ-1:0]       i_ReqOp;
    logic [NREQ*WIDTH-1:0] i_ReqDat;
    logic [NREQ-1:0]       o_ReqRdy;
    logic [NREQ-1:0]       o_RspVld;
    logic [WIDTH-1:0]      o_RspDat;
    logic                  o_RspErr;
    logic                  o_Busy;
    logic                  o_StPush;
    logic                  o_StPop;
    logic [WIDTH-1:0]      o_StPushDat;
    logic [WIDTH-1:0]      i_StPopDat;
    logic                  i_StEmpty;
    logic                  i_StFull;

    logic [WIDTH-1:0] mem [DEPTH];
    int               sp = 0;
    logic             force_full = 1'b0;
    int               checks = 0;
    int               failures = 0;

    always #5 i_Clk = ~i_Clk;

    stack_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W)) dut (
        .i_Clk       (i_Clk),
        .i_Rst       (i_Rst),
        .i_ReqVld    (i_ReqVld),
        .i_ReqOp     (i_ReqOp),
        .i_ReqDat    (i_ReqDat),
        .o_ReqRdy    (o_ReqRdy),
        .o_RspVld    (o_RspVld),
        .o_RspDat    (o_RspDat),
        .o_RspErr    (o_RspErr),
        .o_Busy      (o_Busy),
        .o_StPush    (o_StPush),
        .o_StPop     (o_StPop),
        .o_StPushDat (o_StPushDat),
        .i_StPopDat  (i_StPopDat),
        .i_StEmpty   (i_StEmpty),
        .i_StFull    (i_StFull)
    );

    assign i_StEmpty  = (sp == 0);
    assign i_StFull   = force_full || (sp == DEPTH);
    assign i_StPopDat = (sp > 0) ? mem[sp-1] : '0;

    always @(posedge i_Clk) begin
        if (o_StPush && sp < DEPTH) begin
            mem[sp] <= o_StPushDat;
            sp      <= sp + 1;
        end else if (o_StPop && sp > 0) begin
            sp <= sp - 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_dat(input int k, input logic [WIDTH-1:0] d);
        i_ReqDat[k*WIDTH +: WIDTH] = d;
    endtask

    initial begin
        int order [5];
        order = '{0, 1, 2, 3, 0};
        i_Rst    = 1'b1;
        i_ReqVld = '0;
        i_ReqOp  = '0;
        i_ReqDat = '0;
        repeat (2) @(negedge i_Clk);
        i_Rst = 1'b0;
        @(negedge i_Clk);
        check("rst_busy", 64'(o_Busy), 64'd0);
        check("rst_rdy", 64'(o_ReqRdy), 64'd0);
        check("rst_rspvld", 64'(o_RspVld), 64'd0);

        // Req0 pop on empty stack: error, no strobe; leaves RR at 1
        i_ReqVld = 4'b0001;
        i_ReqOp  = 4'b0000;
        @(negedge i_Clk);
        check("popempty_rdy", 64'(o_ReqRdy), 64'b0001);
        check("popempty_nopop", 64'(o_StPop), 64'd0);
        check("popempty_busy", 64'(o_Busy), 64'd1);
        i_ReqVld = '0;
        @(negedge i_Clk);
        check("popempty_rspvld", 64'(o_RspVld), 64'b0001);
        check("popempty_err", 64'(o_RspErr), 64'd1);
        check("popempty_dat", 64'(o_RspDat), 64'd0);
        @(negedge i_Clk);
        check("popempty_idle", 64'(o_Busy), 64'd0);

        // Reset asserted in the middle of ISSUE
        i_ReqVld = 4'b1000;
        i_ReqOp  = 4'b1000;
        set_dat(3, 32'h0000_0033);
        @(negedge i_Clk);
        check("midrst_pre_rdy", 64'(o_ReqRdy), 64'b1000);
        check("midrst_pre_push", 64'(o_StPush), 64'd1);
        i_Rst = 1'b1;
        #1;
        check("midrst_rdy", 64'(o_ReqRdy), 64'd0);
        check("midrst_push", 64'(o_StPush), 64'd0);
        check("midrst_busy", 64'(o_Busy), 64'd0);
        check("midrst_pushdat", 64'(o_StPushDat), 64'd0);
        i_ReqVld = '0;
        @(negedge i_Clk);
        i_Rst = 1'b0;
        check("midrst_nostore", 64'(sp), 64'd0);

        // Req0 push and Req1 pop together: RR back at 0 grants req0 first
        i_ReqVld = 4'b0011;
        i_ReqOp  = 4'b0001;
        set_dat(0, 32'hA5A5_0001);
        @(negedge i_Clk);
        check("push_rdy", 64'(o_ReqRdy), 64'b0001);
        check("push_strobe", 64'(o_StPush), 64'd1);
        check("push_nopop", 64'(o_StPop), 64'd0);
        check("push_dat", 64'(o_StPushDat), 64'hA5A5_0001);
        i_ReqVld[0] = 1'b0;
        @(negedge i_Clk);
        check("push_rspvld", 64'(o_RspVld), 64'b0001);
        check("push_err", 64'(o_RspErr), 64'd0);
        check("push_rspdat", 64'(o_RspDat), 64'd0);
        @(negedge i_Clk);
        check("push_idle", 64'(o_Busy), 64'd0);
        @(negedge i_Clk);
        check("pop_rdy", 64'(o_ReqRdy), 64'b0010);
        check("pop_strobe", 64'(o_StPop), 64'd1);
        check("pop_nopush", 64'(o_StPush), 64'd0);
        i_ReqVld = '0;
        @(negedge i_Clk);
        check("pop_rspvld", 64'(o_RspVld), 64'b0010);
        check("pop_rspdat", 64'(o_RspDat), 64'hA5A5_0001);
        check("pop_err", 64'(o_RspErr), 64'd0);
        @(negedge i_Clk);
        check("pop_depth", 64'(sp), 64'd0);

        // Push while the stack reports full
        force_full = 1'b1;
        i_ReqVld   = 4'b0100;
        i_ReqOp    = 4'b0100;
        set_dat(2, 32'h0000_0022);
        @(negedge i_Clk);
        check("full_rdy", 64'(o_ReqRdy), 64'b0100);
        check("full_nopush", 64'(o_StPush), 64'd0);
        i_ReqVld = '0;
        @(negedge i_Clk);
        check("full_rspvld", 64'(o_RspVld), 64'b0100);
        check("full_err", 64'(o_RspErr), 64'd1);
        check("full_rspdat", 64'(o_RspDat), 64'd0);
        @(negedge i_Clk);
        force_full = 1'b0;

        // All four requesters push continuously from RR=0
        i_Rst = 1'b1;
        @(negedge i_Clk);
        i_Rst    = 1'b0;
        i_ReqVld = 4'b1111;
        i_ReqOp  = 4'b1111;
        for (int k = 0; k < 4; k++) set_dat(k, 32'h0000_1000 + 32'(k));
        for (int i = 0; i < 5; i++) begin
            @(negedge i_Clk);
            check("rr_rdy", 64'(o_ReqRdy), 64'(4'b0001 << order[i]));
            check("rr_pushdat", 64'(o_StPushDat), 64'h1000 + 64'(order[i]));
            @(negedge i_Clk);
            check("rr_rspvld", 64'(o_RspVld), 64'(4'b0001 << order[i]));
            @(negedge i_Clk);
            check("rr_idle_rdy", 64'(o_ReqRdy), 64'd0);
        end
        i_ReqVld = '0;
        check("rr_depth", 64'(sp), 64'd5);

        // Data changed after grant must not reach the stack
        i_ReqVld = 4'b0100;
        i_ReqOp  = 4'b0100;
        set_dat(2, 32'h0000_BEEF);
        @(posedge i_Clk);
        #1;
        set_dat(2, 32'h0000_DEAD);
        @(negedge i_Clk);
        check("latch_rdy", 64'(o_ReqRdy), 64'b0100);
        check("latch_pushdat", 64'(o_StPushDat), 64'h0000_BEEF);
        i_ReqVld = '0;
        @(negedge i_Clk);
        check("latch_err", 64'(o_RspErr), 64'd0);
        @(negedge i_Clk);
        check("latch_tos", 64'(i_StPopDat), 64'h0000_BEEF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
